// File: rtl/control_fsm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// control_fsm : multi-cycle fetch/decode/execute/memory controller, 16-bit core
// Revision    : 1.0
// ---------------------------------------------------------------------------
module control_fsm #(
    parameter int RST_CYCLES = 2,
    parameter int OPW        = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic [3:0]  flags,
    input  logic        mem_ready,
    output logic        pc_reset,
    output logic        reg_reset,
    output logic        flag_reset,
    output logic        ir_load,
    output logic        pc_inc,
    output logic        pc_load,
    output logic        reg_write,
    output logic        wb_sel_mem,
    output logic [2:0]  alu_op,
    output logic        alu_src_imm,
    output logic        flag_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        halted,
    output logic        illegal
);

    typedef enum logic [2:0] {
        S_RST_SEQ = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXEC    = 3'd3,
        S_MEM     = 3'd4,
        S_HALT    = 3'd5
    } state_t;

    localparam int CNT_W = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES + 1);

    localparam logic [OPW-1:0] OP_ADD  = OPW'(1);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(2);
    localparam logic [OPW-1:0] OP_AND  = OPW'(3);
    localparam logic [OPW-1:0] OP_OR   = OPW'(4);
    localparam logic [OPW-1:0] OP_XOR  = OPW'(5);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(6);
    localparam logic [OPW-1:0] OP_LD   = OPW'(7);
    localparam logic [OPW-1:0] OP_ST   = OPW'(8);
    localparam logic [OPW-1:0] OP_B    = OPW'(9);
    localparam logic [OPW-1:0] OP_BZ   = OPW'(10);
    localparam logic [OPW-1:0] OP_BN   = OPW'(11);
    localparam logic [OPW-1:0] OP_BC   = OPW'(12);
    localparam logic [OPW-1:0] OP_RSV0 = OPW'(13);
    localparam logic [OPW-1:0] OP_RSV1 = OPW'(14);
    localparam logic [OPW-1:0] OP_HALT = OPW'(15);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [OPW-1:0]   r_op;

    // Operand fields and the V flag are consumed by the datapath only.
    logic unused_inputs;
    assign unused_inputs = ^{instr[15-OPW:0], flags[0]};

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_RST_SEQ;
            r_cnt   <= CNT_W'(RST_CYCLES);
        end else begin
            case (r_state)
                S_RST_SEQ: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) r_state <= S_FETCH;
                end
                S_FETCH:  if (mem_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    r_op    <= instr[15 -: OPW];
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    case (r_op)
                        OP_LD, OP_ST: r_state <= S_MEM;
                        OP_HALT:      r_state <= S_HALT;
                        default:      r_state <= S_FETCH;
                    endcase
                end
                S_MEM:    if (mem_ready) r_state <= S_FETCH;
                S_HALT:   r_state <= S_HALT;
                default:  r_state <= S_RST_SEQ;
            endcase
        end
    end

    always_comb begin
        pc_reset    = 1'b0;
        reg_reset   = 1'b0;
        flag_reset  = 1'b0;
        ir_load     = 1'b0;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        reg_write   = 1'b0;
        wb_sel_mem  = 1'b0;
        alu_op      = 3'd0;
        alu_src_imm = 1'b0;
        flag_write  = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        halted      = 1'b0;
        illegal     = 1'b0;
        case (r_state)
            S_RST_SEQ: begin
                pc_reset   = 1'b1;
                reg_reset  = 1'b1;
                flag_reset = 1'b1;
            end
            S_FETCH: begin
                mem_read = 1'b1;
                ir_load  = mem_ready;
                pc_inc   = mem_ready;
            end
            S_EXEC: begin
                case (r_op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        reg_write  = 1'b1;
                        flag_write = 1'b1;
                        case (r_op)
                            OP_SUB:  alu_op = 3'd1;
                            OP_AND:  alu_op = 3'd2;
                            OP_OR:   alu_op = 3'd3;
                            OP_XOR:  alu_op = 3'd4;
                            default: alu_op = 3'd0;
                        endcase
                    end
                    OP_ADDI: begin
                        alu_src_imm = 1'b1;
                        reg_write   = 1'b1;
                        flag_write  = 1'b1;
                    end
                    OP_LD, OP_ST:     alu_src_imm = 1'b1;
                    OP_B:             pc_load = 1'b1;
                    OP_BZ:            pc_load = flags[3];
                    OP_BN:            pc_load = flags[2];
                    OP_BC:            pc_load = flags[1];
                    OP_RSV0, OP_RSV1: illegal = 1'b1;
                    default: ;
                endcase
            end
            S_MEM: begin
                if (r_op == OP_LD) begin
                    mem_read   = 1'b1;
                    reg_write  = mem_ready;
                    wb_sel_mem = mem_ready;
                end else begin
                    mem_write = 1'b1;
                end
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_control_fsm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_control_fsm : directed table, hand sequences and randomized model checks
// Revision       : 1.0
// ---------------------------------------------------------------------------
module tb_control_fsm;

    logic        clk;
    logic        reset;
    logic [15:0] instr;
    logic [3:0]  flags;
    logic        mem_ready;
    logic        pc_reset, reg_reset, flag_reset, ir_load, pc_inc, pc_load;
    logic        reg_write, wb_sel_mem, alu_src_imm, flag_write;
    logic        mem_read, mem_write, halted, illegal;
    logic [2:0]  alu_op;

    int nvec = 0;
    int nerr = 0;

    control_fsm #(.RST_CYCLES(2), .OPW(4)) dut (
        .clk(clk), .reset(reset), .instr(instr), .flags(flags), .mem_ready(mem_ready),
        .pc_reset(pc_reset), .reg_reset(reg_reset), .flag_reset(flag_reset),
        .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load),
        .reg_write(reg_write), .wb_sel_mem(wb_sel_mem), .alu_op(alu_op),
        .alu_src_imm(alu_src_imm), .flag_write(flag_write),
        .mem_read(mem_read), .mem_write(mem_write), .halted(halted), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit layout: pc_reset reg_reset flag_reset ir_load pc_inc pc_load reg_write
    // wb_sel_mem alu_op[2:0] alu_src_imm flag_write mem_read mem_write halted illegal
    logic [16:0] outs;
    assign outs = {pc_reset, reg_reset, flag_reset, ir_load, pc_inc, pc_load, reg_write,
                   wb_sel_mem, alu_op, alu_src_imm, flag_write, mem_read, mem_write,
                   halted, illegal};

    localparam logic [16:0] E_RST   = 17'h1C000;
    localparam logic [16:0] E_WAIT  = 17'h00008;
    localparam logic [16:0] E_FETCH = 17'h03008;
    localparam logic [16:0] E_NONE  = 17'h00000;
    localparam logic [16:0] E_HALT  = 17'h00002;
    localparam logic [16:0] E_STW   = 17'h00004;
    localparam logic [16:0] E_LDW   = 17'h00008;
    localparam logic [16:0] E_LDOK  = 17'h00608;
    localparam logic [16:0] E_ADDR  = 17'h00020;

    typedef struct {
        logic [15:0] ins;
        logic [3:0]  fl;
        logic [16:0] exec_exp;
    } vec_t;

    vec_t tbl[13];

    task automatic cyc(input logic rn, input logic [15:0] ins, input logic [3:0] fl,
                       input logic rdy, input bit chk, input logic [16:0] exp,
                       input string nm);
        reset     = rn;
        instr     = ins;
        flags     = fl;
        mem_ready = rdy;
        @(negedge clk);
        if (chk) begin
            nvec++;
            if (outs !== exp) begin
                nerr++;
                $display("FAIL %s instr=%h flags=%b: got %h expected %h",
                         nm, ins, fl, outs, exp);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Reference: expected EXEC-cycle strobes computed from the opcode semantics.
    function automatic logic [16:0] exec_exp(input int op, input logic [3:0] f);
        logic [16:0] e;
        bit taken;
        e = '0;
        if (op >= 1 && op <= 5) begin
            e = 17'h00410 | (17'(op - 1) << 6);
        end else if (op == 6) begin
            e = 17'h00430;
        end else if (op == 7 || op == 8) begin
            e = E_ADDR;
        end else if (op >= 9 && op <= 12) begin
            taken = (op == 9) || (op == 10 && f[3]) || (op == 11 && f[2]) || (op == 12 && f[1]);
            if (taken) e = 17'h00800;
        end else if (op == 13 || op == 14) begin
            e = 17'h00001;
        end
        return e;
    endfunction

    // One full instruction from FETCH with wf fetch waits and wm memory waits.
    task automatic run_instr(input logic [15:0] ins, input logic [3:0] fl,
                             input int wf, input int wm);
        int op;
        op = int'(ins >> 12);
        for (int i = 0; i < wf; i++) cyc(1'b1, 16'($urandom), fl, 1'b0, 1'b1, E_WAIT, "rnd_fetch_wait");
        cyc(1'b1, 16'($urandom), fl, 1'b1, 1'b1, E_FETCH, "rnd_fetch");
        cyc(1'b1, ins, fl, 1'($urandom_range(1)), 1'b1, E_NONE, "rnd_decode");
        cyc(1'b1, ins, fl, 1'($urandom_range(1)), 1'b1, exec_exp(op, fl), "rnd_exec");
        if (op == 7 || op == 8) begin
            for (int i = 0; i < wm; i++)
                cyc(1'b1, ins, fl, 1'b0, 1'b1, (op == 7) ? E_LDW : E_STW, "rnd_mem_wait");
            cyc(1'b1, ins, fl, 1'b1, 1'b1, (op == 7) ? E_LDOK : E_STW, "rnd_mem_done");
        end
    endtask

    task automatic restart(input string nm);
        cyc(1'b1, 16'h0, 4'h0, 1'b1, 1'b1, E_RST, nm);
        cyc(1'b1, 16'h0, 4'h0, 1'b1, 1'b1, E_RST, nm);
        cyc(1'b1, 16'h0, 4'h0, 1'b0, 1'b1, E_WAIT, "restart_fetch");
    endtask

    initial begin
        tbl[0]  = '{16'h1298, 4'b0000, 17'h00410};
        tbl[1]  = '{16'h2123, 4'b0000, 17'h00450};
        tbl[2]  = '{16'h3123, 4'b1111, 17'h00490};
        tbl[3]  = '{16'h4123, 4'b0000, 17'h004D0};
        tbl[4]  = '{16'h5123, 4'b0000, 17'h00510};
        tbl[5]  = '{16'h6ABC, 4'b0000, 17'h00430};
        tbl[6]  = '{16'hA000, 4'b1000, 17'h00800};
        tbl[7]  = '{16'hA000, 4'b0000, 17'h00000};
        tbl[8]  = '{16'h9000, 4'b0000, 17'h00800};
        tbl[9]  = '{16'hB000, 4'b0100, 17'h00800};
        tbl[10] = '{16'hC000, 4'b0100, 17'h00000};
        tbl[11] = '{16'hD000, 4'b1111, 17'h00001};
        tbl[12] = '{16'h0000, 4'b1111, 17'h00000};

        reset = 1'b0; instr = '0; flags = '0; mem_ready = 1'b0;
        @(posedge clk);
        #1;

        // Power-up: three cycles low, two hold cycles, then fetch.
        cyc(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, E_RST, "rst_first");
        cyc(1'b0, 16'h0, 4'h0, 1'b1, 1'b1, E_RST, "rst_low");
        cyc(1'b0, 16'h0, 4'h0, 1'b1, 1'b1, E_RST, "rst_low");
        restart("rst_hold");

        foreach (tbl[k]) begin
            cyc(1'b1, 16'h0, tbl[k].fl, 1'b1, 1'b1, E_FETCH, "tbl_fetch");
            cyc(1'b1, tbl[k].ins, tbl[k].fl, 1'b0, 1'b1, E_NONE, "tbl_decode");
            cyc(1'b1, tbl[k].ins, tbl[k].fl, 1'b1, 1'b1, tbl[k].exec_exp, "tbl_exec");
        end

        // LD with two fetch waits and three memory waits: nine cycles.
        cyc(1'b1, 16'h0, 4'h0, 1'b0, 1'b1, E_WAIT, "ld_fetch_wait");
        cyc(1'b1, 16'h0, 4'h0, 1'b0, 1'b1, E_WAIT, "ld_fetch_wait");
        cyc(1'b1, 16'h0, 4'h0, 1'b1, 1'b1, E_FETCH, "ld_fetch");
        cyc(1'b1, 16'h7285, 4'h0, 1'b1, 1'b1, E_NONE, "ld_decode");
        cyc(1'b1, 16'h7285, 4'h0, 1'b1, 1'b1, E_ADDR, "ld_exec");
        for (int i = 0; i < 3; i++) cyc(1'b1, 16'h7285, 4'h0, 1'b0, 1'b1, E_LDW, "ld_mem_wait");
        cyc(1'b1, 16'h7285, 4'h0, 1'b1, 1'b1, E_LDOK, "ld_mem_done");

        // ST interrupted by reset while waiting on memory.
        cyc(1'b1, 16'h0, 4'h0, 1'b1, 1'b1, E_FETCH, "st_fetch");
        cyc(1'b1, 16'h8123, 4'h0, 1'b0, 1'b1, E_NONE, "st_decode");
        cyc(1'b1, 16'h8123, 4'h0, 1'b0, 1'b1, E_ADDR, "st_exec");
        cyc(1'b1, 16'h8123, 4'h0, 1'b0, 1'b1, E_STW, "st_mem_wait");
        cyc(1'b0, 16'h8123, 4'h0, 1'b0, 1'b1, E_STW, "st_pre_reset");
        cyc(1'b0, 16'h8123, 4'h0, 1'b1, 1'b1, E_RST, "st_reset_drop");
        restart("st_restart_hold");

        for (int n = 0; n < 300; n++) begin
            logic [15:0] ins;
            ins = 16'($urandom);
            if (ins[15:12] == 4'hF) ins[15:12] = 4'h0;
            run_instr(ins, 4'($urandom), int'($urandom_range(3)), int'($urandom_range(3)));
        end

        // HALT holds through mem_ready activity until reset.
        cyc(1'b1, 16'h0, 4'h0, 1'b1, 1'b1, E_FETCH, "halt_fetch");
        cyc(1'b1, 16'hF000, 4'hF, 1'b1, 1'b1, E_NONE, "halt_decode");
        cyc(1'b1, 16'hF000, 4'hF, 1'b1, 1'b1, E_NONE, "halt_exec");
        for (int i = 0; i < 20; i++) cyc(1'b1, 16'hF000, 4'hF, 1'(i), 1'b1, E_HALT, "halt_hold");
        cyc(1'b0, 16'h0, 4'h0, 1'b1, 1'b1, E_HALT, "halt_pre_reset");
        cyc(1'b0, 16'h0, 4'h0, 1'b1, 1'b1, E_RST, "halt_reset");
        restart("halt_restart_hold");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/control_fsm.md
Name: control_fsm

Overview:
Multi-cycle control unit that drives the 16-bit datapath. It sequences the datapath reset strobes (pc_reset, reg_reset, flag_reset) at power-up and on reset. It then runs fetch/decode/execute/memory over the instruction word held in the datapath IR, and issues the register, ALU, PC, flag and memory strobes the datapath consumes. It also implements the bus-side read/write handshake.

Parameters:
RST_CYCLES, 2, cycles the datapath reset strobes stay high after reset deasserts (min 1)
OPW, 4, opcode width, taken from instr[15:12]

Ports:
clk  input  1  system clock, all state changes on rising edge
reset  input  1  synchronous, active-low; sampled on rising edge of clk
instr  input  16  IR contents from datapath; valid from DECODE onward
flags  input  4  {Z,N,C,V} from datapath flag register
mem_ready  input  1  memory handshake completion, one-cycle pulse or level
pc_reset  output  1  datapath PC clear
reg_reset  output  1  datapath register-file clear
flag_reset  output  1  datapath flag clear
ir_load  output  1  latch memory data into IR
pc_inc  output  1  PC <= PC+1
pc_load  output  1  PC <= branch target (datapath computes target)
reg_write  output  1  write rd
wb_sel_mem  output  1  writeback source: 1=memory data, 0=ALU
alu_op  output  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 7 PASS_A
alu_src_imm  output  1  ALU B operand = sign-extended imm6
flag_write  output  1  update flags from ALU
mem_read  output  1  memory read request
mem_write  output  1  memory write request
halted  output  1  core stopped
illegal  output  1  one-cycle pulse on reserved opcode

Behaviour:
- States: RST_SEQ, FETCH, DECODE, EXEC, MEM, HALT. All outputs are decoded from state and instr (Moore w.r.t. state). Every strobe not listed for a state is 0.
- Reset low at any edge, mid-instruction included:
  - Next state is RST_SEQ and the counter loads RST_CYCLES.
  - pc_reset, reg_reset and flag_reset read 1 in RST_SEQ; all other outputs read 0.
  - An in-flight mem_read or mem_write is dropped the same cycle.
- RST_SEQ with reset high: counter decrements each cycle. When it reaches 0 (exactly RST_CYCLES cycles high), the next state is FETCH.
- FETCH:
  - mem_read=1 is held until mem_ready.
  - In the mem_ready cycle, ir_load=1 and pc_inc=1, then go to DECODE.
  - No timeout.
- DECODE: one cycle, no strobes. The opcode is latched internally, then go to EXEC.
- Opcode map (instr[15:12]):
  - 0 NOP
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR
  - 6 ADDI
  - 7 LD, 8 ST
  - 9 B, A BZ, B BN, C BC
  - D, E reserved
  - F HALT
- EXEC actions by opcode:
  - 1-5: alu_op per map, reg_write=1, flag_write=1, then FETCH.
  - 6 (ADDI): alu_op=ADD, alu_src_imm=1, reg_write=1, flag_write=1, then FETCH.
  - 7, 8 (LD/ST): alu_op=ADD, alu_src_imm=1 (address), then MEM.
  - 9-C (branches): pc_load=1 iff the condition holds (B always; BZ on Z=flags[3]; BN on N=flags[2]; BC on C=flags[1]), then FETCH. flag_write stays 0.
  - 0 (NOP): go to FETCH.
  - D, E: illegal=1 for the single EXEC cycle, otherwise treated as NOP.
  - F: go to HALT.
- MEM:
  - LD holds mem_read=1. In the mem_ready cycle, reg_write=1 and wb_sel_mem=1, then FETCH.
  - ST holds mem_write=1 until mem_ready, then FETCH.
  - Flags are unchanged by LD and ST.
- HALT: halted=1, no strobes. Exit only via reset.
- Latency with zero-wait memory (mem_ready high on first request cycle):
  - ALU, branch or NOP: 3 cycles.
  - LD or ST: 4 cycles.
- mem_ready while not in FETCH or MEM is ignored.
- At most one of pc_inc and pc_load is 1 in any cycle. reg_write and mem_write are never both 1.

Test Plan:
- Reset sequencing: reset low 3 cycles, then high -> pc_reset, reg_reset and flag_reset are 1 throughout reset low plus exactly 2 cycles after. First mem_read=1 occurs in the 3rd cycle after release.
- ALU op, mem_ready tied 1, instr=0x1298 (ADD r1,r2,r3) -> FETCH shows ir_load=pc_inc=1. EXEC (cycle 3) shows alu_op=0, reg_write=1, flag_write=1. Next FETCH follows.
- Wait states: instr=0x7285 (LD), mem_ready withheld 2 cycles in FETCH and 3 in MEM -> mem_read is held high throughout each wait. reg_write=1 and wb_sel_mem=1 occur only in the mem_ready cycle. Total 9 cycles.
- Branches: BZ (0xA000) with flags=4'b1000 -> pc_load=1 in EXEC. With flags=4'b0000 -> pc_load=0. B (0x9000) -> pc_load=1 regardless of flags.
- Reserved opcode 0xD000 -> illegal=1 for exactly one cycle and no other strobes. HALT 0xF000 -> halted=1 held for 20 cycles despite mem_ready toggling; reset low clears it to 0.
- Reset mid-op: drop reset during an ST MEM wait -> mem_write=0 at the next edge, state RST_SEQ with the reset strobes high. Normal restart follows.
